// File: rtl/uart_tx_pkg.sv
// Shared definitions for the UART transmitter: FSM encoding, frame bit levels, prescale floor.
// The PARITY state exists only when UART_TX_PARITY_EN is defined.
package uart_tx_pkg;

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } tx_state_e;
`else
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd4
  } tx_state_e;
`endif

  localparam logic       START_BIT    = 1'b0;
  localparam logic       STOP_BIT     = 1'b1;
  localparam logic [5:0] MIN_PRESCALE = 6'd4;

  // Prescale values below the floor are too short to be a usable bit time.
  function automatic logic [5:0] eff_prescale(input logic [5:0] ps);
    return (ps < MIN_PRESCALE) ? MIN_PRESCALE : ps;
  endfunction

endpackage

// File: rtl/uart_tx_bit_timer.sv
// Edge counter (cycles within a bit) and bit counter (data bits sent) for uart_tx_ctrl.
module uart_tx_bit_timer
  import uart_tx_pkg::*;
#(
  parameter int IN_DATA_WIDTH = 8
) (
  input  logic                               clk_i,
  input  logic                               rst_i,
  input  logic                               run_i,
  input  logic                               bit_cnt_en_i,
  input  logic [5:0]                         presc_i,
  output logic [5:0]                         edge_cnt,
  output logic [$clog2(IN_DATA_WIDTH):0]     bit_cnt,
  output logic                               bit_done
);

  localparam int BW = $clog2(IN_DATA_WIDTH) + 1;

  logic [5:0]    edge_cnt_q;
  logic [BW-1:0] bit_cnt_q;

  assign bit_done = run_i && (edge_cnt_q == (presc_i - 6'd1));

  always_ff @(posedge clk_i) begin
    if (rst_i || !run_i || bit_done) begin
      edge_cnt_q <= '0;
    end else begin
      edge_cnt_q <= edge_cnt_q + 6'd1;
    end
  end

  // Only data bits are counted; the count is held at zero in every other state.
  always_ff @(posedge clk_i) begin
    if (rst_i || !bit_cnt_en_i) begin
      bit_cnt_q <= '0;
    end else if (bit_done) begin
      bit_cnt_q <= bit_cnt_q + 1'b1;
    end
  end

  assign edge_cnt = edge_cnt_q;
  assign bit_cnt  = bit_cnt_q;

endmodule

// File: rtl/uart_tx_ctrl.sv
// UART frame transmitter: start, data LSB first, optional parity, stop; registered TX_OUT.
// Parity generation is built only when UART_TX_PARITY_EN is defined.
module uart_tx_ctrl
  import uart_tx_pkg::*;
#(
  parameter int IN_DATA_WIDTH = 8
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic [IN_DATA_WIDTH-1:0] P_DATA,
  input  logic                     DATA_VALID,
  input  logic                     PAR_EN,
  input  logic                     PAR_TYP,
  input  logic [5:0]               prescale,
  output logic                     TX_OUT,
  output logic                     busy
);

  localparam int            BW       = $clog2(IN_DATA_WIDTH) + 1;
  localparam logic [BW-1:0] LAST_BIT = BW'(IN_DATA_WIDTH - 1);

  tx_state_e                state_q, state_d;
  logic                     tx_q, tx_d;
  logic                     busy_q, busy_d;
  logic [IN_DATA_WIDTH-1:0] sh_q, sh_d;
  logic [5:0]               presc_q, presc_d;

  logic [5:0]    edge_cnt;
  logic [BW-1:0] bit_cnt;
  logic          bit_done;

  uart_tx_bit_timer #(
    .IN_DATA_WIDTH(IN_DATA_WIDTH)
  ) u_timer (
    .clk_i       (CLK),
    .rst_i       (RST),
    .run_i       (state_q != IDLE),
    .bit_cnt_en_i(state_q == DATA),
    .presc_i     (presc_q),
    .edge_cnt    (edge_cnt),
    .bit_cnt     (bit_cnt),
    .bit_done    (bit_done)
  );

  logic unused_edge;
  assign unused_edge = ^edge_cnt;

`ifdef UART_TX_PARITY_EN
  logic par_en_q, par_en_d;
  logic par_bit_q, par_bit_d;
`else
  logic unused_par;
  assign unused_par = PAR_EN ^ PAR_TYP;
`endif

  always_comb begin
    state_d = state_q;
    tx_d    = tx_q;
    busy_d  = busy_q;
    sh_d    = sh_q;
    presc_d = presc_q;
`ifdef UART_TX_PARITY_EN
    par_en_d  = par_en_q;
    par_bit_d = par_bit_q;
`endif
    case (state_q)
      IDLE: begin
        tx_d   = STOP_BIT;
        busy_d = 1'b0;
        if (DATA_VALID) begin
          state_d = START;
          tx_d    = START_BIT;
          busy_d  = 1'b1;
          sh_d    = P_DATA;
          presc_d = eff_prescale(prescale);
`ifdef UART_TX_PARITY_EN
          par_en_d  = PAR_EN;
          par_bit_d = (^P_DATA) ^ PAR_TYP;
`endif
        end
      end
      START: begin
        if (bit_done) begin
          state_d = DATA;
          tx_d    = sh_q[0];
          sh_d    = sh_q >> 1;
        end
      end
      DATA: begin
        if (bit_done) begin
          if (bit_cnt == LAST_BIT) begin
            state_d = STOP;
            tx_d    = STOP_BIT;
`ifdef UART_TX_PARITY_EN
            if (par_en_q) begin
              state_d = PARITY;
              tx_d    = par_bit_q;
            end
`endif
          end else begin
            tx_d = sh_q[0];
            sh_d = sh_q >> 1;
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (bit_done) begin
          state_d = STOP;
          tx_d    = STOP_BIT;
        end
      end
`endif
      STOP: begin
        if (bit_done) begin
          state_d = IDLE;
          tx_d    = STOP_BIT;
          busy_d  = 1'b0;
        end
      end
      default: begin
        state_d = IDLE;
        tx_d    = STOP_BIT;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      tx_q    <= STOP_BIT;
      busy_q  <= 1'b0;
      sh_q    <= '0;
      presc_q <= '0;
    end else begin
      state_q <= state_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
      sh_q    <= sh_d;
      presc_q <= presc_d;
    end
  end

`ifdef UART_TX_PARITY_EN
  always_ff @(posedge CLK) begin
    if (RST) begin
      par_en_q  <= 1'b0;
      par_bit_q <= 1'b0;
    end else begin
      par_en_q  <= par_en_d;
      par_bit_q <= par_bit_d;
    end
  end
`endif

  assign TX_OUT = tx_q;
  assign busy   = busy_q;

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Scoreboard bench for uart_tx_ctrl: expected frames queued at request time, checked cycle by cycle.
module tb_uart_tx_ctrl;

  localparam int W = 8;
`ifdef UART_TX_PARITY_EN
  localparam bit PAR_BUILT = 1'b1;
`else
  localparam bit PAR_BUILT = 1'b0;
`endif

  typedef struct {
    logic [7:0] data;
    bit         pe;
    bit         pt;
    int         presc;
  } exp_t;

  logic         CLK = 1'b0;
  logic         RST;
  logic [W-1:0] P_DATA;
  logic         DATA_VALID;
  logic         PAR_EN;
  logic         PAR_TYP;
  logic [5:0]   prescale;
  logic         TX_OUT;
  logic         busy;

  int   n_tests = 0;
  int   n_fail  = 0;
  bit   mon_en  = 1'b0;
  bit   mon_busy = 1'b0;
  exp_t exp_q[$];

  always #5 CLK = ~CLK;

  uart_tx_ctrl #(.IN_DATA_WIDTH(W)) dut (
    .CLK       (CLK),
    .RST       (RST),
    .P_DATA    (P_DATA),
    .DATA_VALID(DATA_VALID),
    .PAR_EN    (PAR_EN),
    .PAR_TYP   (PAR_TYP),
    .prescale  (prescale),
    .TX_OUT    (TX_OUT),
    .busy      (busy)
  );

  task automatic check_eq(input string tag, input int obs, input int exp);
    n_tests++;
    if (obs != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  function automatic exp_t make_exp(input logic [7:0] d, input bit pe, input bit pt,
                                    input logic [5:0] ps);
    exp_t e;
    e.data  = d;
    e.pe    = pe;
    e.pt    = pt;
    e.presc = (ps < 6'd4) ? 4 : int'(ps);
    return e;
  endfunction

  task automatic run_frame(input exp_t e);
    logic       bits[$];
    int         busy_cycles;
    logic [7:0] d;
    d = e.data;
    busy_cycles = 0;
    bits.push_back(1'b0);
    for (int i = 0; i < W; i++) bits.push_back(d[i]);
    if (PAR_BUILT && e.pe) bits.push_back((^d) ^ e.pt);
    bits.push_back(1'b1);
    for (int b = 0; b < bits.size(); b++) begin
      for (int c = 0; c < e.presc; c++) begin
        if (b != 0 || c != 0) @(negedge CLK);
        check_eq($sformatf("frame_%02h_bit%0d_cyc%0d", d, b, c), int'(TX_OUT), int'(bits[b]));
        if (busy === 1'b1) busy_cycles++;
      end
    end
    @(negedge CLK);
    check_eq($sformatf("frame_%02h_busy_len", d), busy_cycles, bits.size() * e.presc);
    check_eq($sformatf("frame_%02h_end_busy", d), int'(busy), 0);
    check_eq($sformatf("frame_%02h_end_tx", d), int'(TX_OUT), 1);
  endtask

  // Monitor: every frame the DUT starts must match the oldest queued expectation.
  initial begin
    forever begin
      @(negedge CLK);
      if (mon_en && busy === 1'b1) begin
        mon_busy = 1'b1;
        if (exp_q.size() == 0) begin
          check_eq("spurious_frame", 1, 0);
          for (int k = 0; k < 2000 && busy === 1'b1; k++) @(negedge CLK);
        end else begin
          run_frame(exp_q.pop_front());
        end
        mon_busy = 1'b0;
      end
    end
  end

  task automatic send(input logic [7:0] d, input bit pe, input bit pt, input logic [5:0] ps);
    P_DATA     = d;
    PAR_EN     = pe;
    PAR_TYP    = pt;
    prescale   = ps;
    DATA_VALID = 1'b1;
    exp_q.push_back(make_exp(d, pe, pt, ps));
    @(negedge CLK);
    DATA_VALID = 1'b0;
  endtask

  task automatic wait_idle();
    int k;
    k = 0;
    @(negedge CLK);
    while ((busy !== 1'b0 || mon_busy || exp_q.size() != 0) && k < 3000) begin
      @(negedge CLK);
      k++;
    end
    check_eq("idle_timeout", int'(k >= 3000), 0);
    repeat (4) @(negedge CLK);
  endtask

  initial begin
    int gap;
    int k;
    int busy_seen;
    int tx_low_seen;

    RST        = 1'b1;
    DATA_VALID = 1'b1;
    P_DATA     = 8'h55;
    PAR_EN     = 1'b0;
    PAR_TYP    = 1'b0;
    prescale   = 6'd4;
    repeat (3) @(negedge CLK);
    check_eq("rst_tx", int'(TX_OUT), 1);
    check_eq("rst_busy", int'(busy), 0);
    RST        = 1'b0;
    DATA_VALID = 1'b0;
    @(negedge CLK);
    check_eq("post_rst_busy", int'(busy), 0);
    check_eq("post_rst_tx", int'(TX_OUT), 1);
    mon_en = 1'b1;

    // Single frames with and without parity, different prescales
    send(8'hA5, 1'b1, 1'b0, 6'd8);
    wait_idle();
    send(8'h01, 1'b1, 1'b1, 6'd4);
    wait_idle();
    send(8'h01, 1'b0, 1'b1, 6'd4);
    wait_idle();

    // Back-to-back with DATA_VALID held; data changed mid-frame
    P_DATA     = 8'h3C;
    PAR_EN     = 1'b1;
    PAR_TYP    = 1'b1;
    prescale   = 6'd4;
    DATA_VALID = 1'b1;
    exp_q.push_back(make_exp(8'h3C, 1'b1, 1'b1, 6'd4));
    @(negedge CLK);
    P_DATA = 8'hC3;
    exp_q.push_back(make_exp(8'hC3, 1'b1, 1'b1, 6'd4));
    k = 0;
    while (busy === 1'b1 && k < 200) begin
      @(negedge CLK);
      k++;
    end
    gap = 0;
    while (busy === 1'b0 && gap < 50) begin
      gap++;
      @(negedge CLK);
    end
    DATA_VALID = 1'b0;
    check_eq("b2b_gap", gap, 1);
    wait_idle();

    // Request during DATA bit 3 must be ignored
    send(8'h00, 1'b0, 1'b0, 6'd4);
    repeat (17) @(negedge CLK);
    P_DATA     = 8'hFF;
    PAR_EN     = 1'b1;
    prescale   = 6'd6;
    DATA_VALID = 1'b1;
    @(negedge CLK);
    DATA_VALID = 1'b0;
    wait_idle();
    repeat (8) @(negedge CLK);

    // Prescale below floor at acceptance, then raised mid-frame
    send(8'h96, 1'b1, 1'b0, 6'd2);
    prescale = 6'd16;
    PAR_TYP  = 1'b1;
    wait_idle();

    // Reset during DATA bit 5
    mon_en = 1'b0;
    send(8'h00, 1'b0, 1'b0, 6'd4);
    repeat (25) @(negedge CLK);
    check_eq("pre_rst_tx", int'(TX_OUT), 0);
    check_eq("pre_rst_busy", int'(busy), 1);
    RST = 1'b1;
    @(negedge CLK);
    RST = 1'b0;
    check_eq("abort_tx", int'(TX_OUT), 1);
    check_eq("abort_busy", int'(busy), 0);
    exp_q.delete();
    busy_seen   = 0;
    tx_low_seen = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge CLK);
      if (busy !== 1'b0) busy_seen++;
      if (TX_OUT !== 1'b1) tx_low_seen++;
    end
    check_eq("abort_idle_busy_cycles", busy_seen, 0);
    check_eq("abort_idle_tx_low_cycles", tx_low_seen, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
